// File: rtl/paddsb_pkg.sv
// ---------------------------------------------------------------------------
// paddsb_pkg
//   Shared types and constants for the PADDSB arbiter slice.
//   - NIB_W / NLANES : lane geometry of the 16-bit packed word (4 x 4-bit).
//   - SAT_POS/SAT_NEG: clamp values used when a lane saturates.
//   - slot_state_t   : occupancy of the one-entry registered output slot.
//   - word_t         : one packed 16-bit operand/result.
//   - popcount4      : counts saturated lanes (used by the optional
//                      statistics counters, PADDSB_ARB_STATS_EN).
// ---------------------------------------------------------------------------
package paddsb_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned NLANES = 4;

  localparam logic [NIB_W-1:0] SAT_POS = 4'h7;
  localparam logic [NIB_W-1:0] SAT_NEG = 4'h8;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

  typedef logic [15:0] word_t;

  function automatic logic [2:0] popcount4(input logic [NLANES-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < NLANES; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/paddsb_lane.sv
// ---------------------------------------------------------------------------
// paddsb_lane
//   One 4-bit two's-complement saturating adder lane (purely combinational).
//   Ports:
//     a, b  in  4  signed operands
//     sum   out 4  a+b, clamped to 4'h7 / 4'h8 on signed overflow
//     ovfl  out 1  set when the lane clamped
// ---------------------------------------------------------------------------
module paddsb_lane
  import paddsb_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [NIB_W-1:0] sum,
  output logic             ovfl
);

  logic [NIB_W-1:0] raw;

  // Carry out of the nibble is dropped on purpose: lanes never interact.
  assign raw  = a + b;

  // Signed overflow is only possible when both operands share a sign and
  // the wrapped result flips it.
  assign ovfl = (a[NIB_W-1] == b[NIB_W-1]) && (raw[NIB_W-1] != a[NIB_W-1]);

  assign sum  = ovfl ? (a[NIB_W-1] ? SAT_NEG : SAT_POS) : raw;

endmodule

// File: rtl/paddsb_arb.sv
// ---------------------------------------------------------------------------
// paddsb_arb
//   Round-robin arbiter sharing one 16-bit PADDSB (4-lane saturating add)
//   among NREQ requesters, with a one-entry registered result slot.
//
//   Parameters:
//     NREQ  number of requesters (2..4)
//     IDW   width of rsp_id, must equal clog2(NREQ)
//
//   Ports:
//     clk        in   1          rising-edge clock
//     rst        in   1          asynchronous active-high reset
//     req_valid  in   NREQ       per-requester request
//     req_a      in   16*NREQ    operand A, requester i at [16i+15:16i]
//     req_b      in   16*NREQ    operand B, same packing
//     req_ready  out  NREQ       one-hot grant (combinational)
//     rsp_valid  out  1          slot holds a result
//     rsp_data   out  16         saturated lane-wise sum
//     rsp_id     out  IDW        requester that produced the result
//     rsp_ovfl   out  4          per-lane saturation flags
//     rsp_ready  in   1          consumer accepts the result
//   Optional (macro PADDSB_ARB_STATS_EN):
//     stat_ops   out  16         accepted operations, wraps
//     stat_sat   out  16         saturated lanes over all accepts, wraps
//
//   A new request can be accepted in the same cycle the slot drains, so a
//   continuously ready consumer sees one result per cycle with no bubbles.
// ---------------------------------------------------------------------------
module paddsb_arb
  import paddsb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic [NLANES-1:0]    rsp_ovfl,
  input  logic                 rsp_ready
`ifdef PADDSB_ARB_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_sat
`endif
);

  localparam int unsigned WW = $bits(word_t);

  slot_state_t       state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    win_idx;
  logic              found;
  logic              slot_free;
  logic              accept;
  logic [NREQ-1:0]   grant;

  word_t             win_a, win_b;
  word_t             win_sum;
  logic [NLANES-1:0] win_ovfl;

  word_t             data_q;
  logic [IDW-1:0]    id_q;
  logic [NLANES-1:0] ovfl_q;

  // -------------------------------------------------------------------------
  // Arbitration. Round-robin from ptr is done as two priority passes instead
  // of a modulo search: first requesters at or above ptr, then those below.
  // -------------------------------------------------------------------------
  assign slot_free = (state_q == SLOT_EMPTY) || (rsp_ready && (state_q == SLOT_FULL));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= ptr_q)) begin
        found   = 1'b1;
        win_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) < ptr_q)) begin
        found   = 1'b1;
        win_idx = IDW'(i);
      end
    end
  end

  // rst is folded in so no requester sees a grant while reset is held.
  assign accept = found && slot_free && !rst;

  always_comb begin
    grant = '0;
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_idx) begin
        grant[i] = accept;
        win_a    = req_a[i*WW +: WW];
        win_b    = req_b[i*WW +: WW];
      end
    end
  end

  assign req_ready = grant;

  // -------------------------------------------------------------------------
  // Shared datapath: four independent lanes on the winner's operands.
  // -------------------------------------------------------------------------
  for (genvar n = 0; n < NLANES; n++) begin : g_lane
    paddsb_lane u_lane (
      .a    (win_a[n*NIB_W +: NIB_W]),
      .b    (win_b[n*NIB_W +: NIB_W]),
      .sum  (win_sum[n*NIB_W +: NIB_W]),
      .ovfl (win_ovfl[n])
    );
  end

  // -------------------------------------------------------------------------
  // Slot FSM and round-robin pointer (next-state logic).
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = SLOT_FULL;
      ptr_d   = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
    end else if ((state_q == SLOT_FULL) && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Result slot. Loads only on accept; a plain drain leaves the last values
  // visible on rsp_data/rsp_id/rsp_ovfl.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the payload registers are reset too, because the output word is
    // architecturally defined as zero after reset, not just invalid.
    if (rst) begin
      data_q <= '0;
      id_q   <= '0;
      ovfl_q <= '0;
    end else if (accept) begin
      data_q <= win_sum;
      id_q   <= win_idx;
      ovfl_q <= win_ovfl;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_ovfl  = ovfl_q;

`ifdef PADDSB_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics: both counters wrap naturally at 16 bits.
  // -------------------------------------------------------------------------
  logic [15:0] ops_q, sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q <= '0;
      sat_q <= '0;
    end else if (accept) begin
      ops_q <= ops_q + 16'd1;
      sat_q <= sat_q + {13'd0, popcount4(win_ovfl)};
    end
  end

  assign stat_ops = ops_q;
  assign stat_sat = sat_q;
`endif

endmodule

// File: tb/tb_paddsb_arb.sv
// ---------------------------------------------------------------------------
// tb_paddsb_arb
//   Directed self-checking bench for paddsb_arb with NREQ=2.
//   Inputs change 1 time unit after a rising edge; outputs are compared at
//   that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_paddsb_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [0:0]  rsp_id;
  logic [3:0]  rsp_ovfl;
  logic        rsp_ready;
`ifdef PADDSB_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_sat;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  paddsb_arb #(.NREQ(2), .IDW(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovfl  (rsp_ovfl),
    .rsp_ready (rsp_ready)
`ifdef PADDSB_ARB_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_sat  (stat_sat)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h1234};
    req_b     = {16'h0000, 16'h1111};
    tick();
    tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h exp 0000", rsp_data); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b exp 0", rsp_id); end
    n_checks++; if (rsp_ovfl !== 4'h0) begin n_fail++; $display("FAIL reset_ovfl: got %b exp 0000", rsp_ovfl); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_grant: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h2345) begin n_fail++; $display("FAIL basic_data: got %h exp 2345", rsp_data); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %b exp 0", rsp_id); end
    n_checks++; if (rsp_ovfl !== 4'b0000) begin n_fail++; $display("FAIL basic_ovfl: got %b exp 0000", rsp_ovfl); end
  endtask

  // -------------------------------------------------------------------------
  // The last vector comes from requester 1 so the pointer returns to 0.
  logic [15:0] sat_a  [3] = '{16'h7777, 16'h8888, 16'h7F80};
  logic [15:0] sat_b  [3] = '{16'h1111, 16'hFFFF, 16'h1F80};
  logic [15:0] sat_d  [3] = '{16'h7777, 16'h8888, 16'h7E80};
  logic [3:0]  sat_o  [3] = '{4'b1111, 4'b1111, 4'b1010};
  logic        sat_r  [3] = '{1'b0, 1'b0, 1'b1};

  task automatic test_saturation();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (sat_r[k]) begin
        req_valid = 2'b10;
        req_a     = {sat_a[k], 16'h0000};
        req_b     = {sat_b[k], 16'h0000};
      end else begin
        req_valid = 2'b01;
        req_a     = {16'h0000, sat_a[k]};
        req_b     = {16'h0000, sat_b[k]};
      end
      #1;
      n_checks++; if (req_ready !== req_valid) begin n_fail++; $display("FAIL sat%0d_grant: got %b exp %b", k, req_ready, req_valid); end
      tick();
      req_valid = 2'b00;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sat%0d_valid: got %b exp 1", k, rsp_valid); end
      n_checks++; if (rsp_data !== sat_d[k]) begin n_fail++; $display("FAIL sat%0d_data: got %h exp %h", k, rsp_data, sat_d[k]); end
      n_checks++; if (rsp_ovfl !== sat_o[k]) begin n_fail++; $display("FAIL sat%0d_ovfl: got %b exp %b", k, rsp_ovfl, sat_o[k]); end
      n_checks++; if (rsp_id !== sat_r[k]) begin n_fail++; $display("FAIL sat%0d_id: got %b exp %b", k, rsp_id, sat_r[k]); end
    end
    // Drain without a new request: slot empties, payload is kept.
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h7E80) begin n_fail++; $display("FAIL drain_data_held: got %h exp 7e80", rsp_data); end
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL drain_id_held: got %b exp 1", rsp_id); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [1:0]  exp_grant;
    logic [0:0]  exp_id;
    logic [15:0] exp_data;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_a     = {16'h0303, 16'h0101};
    req_b     = {16'h0101, 16'h0101};
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id    = (k % 2 == 0) ? 1'b0 : 1'b1;
      exp_grant = exp_id ? 2'b10 : 2'b01;
      exp_data  = exp_id ? 16'h0404 : 16'h0202;
      n_checks++; if (req_ready !== exp_grant) begin n_fail++; $display("FAIL rr%0d_grant: got %b exp %b", k, req_ready, exp_grant); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr%0d_valid: got %b exp 1", k, rsp_valid); end
      n_checks++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL rr%0d_id: got %b exp %b", k, rsp_id, exp_id); end
      n_checks++; if (rsp_data !== exp_data) begin n_fail++; $display("FAIL rr%0d_data: got %h exp %h", k, rsp_data, exp_data); end
    end
    req_valid = 2'b00;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b exp 0", rsp_valid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_backpressure();
    // Pointer is 0 here; fill the slot from requester 0 and stall it.
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_a     = {16'h2222, 16'h0000};
    req_b     = {16'h1111, 16'h0001};
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp%0d_grant: got %b exp 00", k, req_ready); end
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid: got %b exp 1", k, rsp_valid); end
      n_checks++; if (rsp_data !== 16'h0001) begin n_fail++; $display("FAIL bp%0d_data: got %h exp 0001", k, rsp_data); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp%0d_id: got %b exp 0", k, rsp_id); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release_grant: got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_release_id: got %b exp 1", rsp_id); end
    n_checks++; if (rsp_data !== 16'h3333) begin n_fail++; $display("FAIL bp_release_data: got %h exp 3333", rsp_data); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    // Slot is FULL (id 1) and stalled; pointer is 0 but reset must clear it
    // anyway, so set up a case where a stale pointer of 1 would differ:
    // the previous accept was requester 1, so ptr is 0 already. Assert reset
    // mid-cycle and confirm it acts without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0000) begin n_fail++; $display("FAIL areset_data: got %h exp 0000", rsp_data); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL areset_id: got %b exp 0", rsp_id); end
    n_checks++; if (rsp_ovfl !== 4'h0) begin n_fail++; $display("FAIL areset_ovfl: got %b exp 0000", rsp_ovfl); end
    req_valid = 2'b11;
    req_a     = {16'h0505, 16'h1111};
    req_b     = {16'h0101, 16'h2222};
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL areset_ready: got %b exp 00", req_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL areset_first_grant: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL areset_first_id: got %b exp 0", rsp_id); end
    n_checks++; if (rsp_data !== 16'h3333) begin n_fail++; $display("FAIL areset_first_data: got %h exp 3333", rsp_data); end
    rsp_ready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_drain: got %b exp 0", rsp_valid); end
  endtask

  // Reset from a stalled FULL slot whose last winner was requester 0, so a
  // pointer that failed to reset would favour requester 1.
  task automatic test_reset_ptr();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h0001};
    req_b     = {16'h0000, 16'h0001};
    tick();
    req_valid = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req_valid = 2'b11;
    req_a     = {16'h0002, 16'h0001};
    req_b     = {16'h0002, 16'h0001};
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_ptr_grant: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    n_checks++; if (rsp_data !== 16'h0002) begin n_fail++; $display("FAIL reset_ptr_data: got %h exp 0002", rsp_data); end
    tick();
  endtask

`ifdef PADDSB_ARB_STATS_EN
  task automatic test_stats();
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    n_checks++; if (stat_ops !== 16'd0) begin n_fail++; $display("FAIL stats_reset_ops: got %0d exp 0", stat_ops); end
    n_checks++; if (stat_sat !== 16'd0) begin n_fail++; $display("FAIL stats_reset_sat: got %0d exp 0", stat_sat); end
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h7777};
    req_b     = {16'h0000, 16'h1111};
    tick();
    n_checks++; if (stat_ops !== 16'd1) begin n_fail++; $display("FAIL stats_ops1: got %0d exp 1", stat_ops); end
    n_checks++; if (stat_sat !== 16'd4) begin n_fail++; $display("FAIL stats_sat1: got %0d exp 4", stat_sat); end
    req_a     = {16'h0000, 16'h0001};
    req_b     = {16'h0000, 16'h0001};
    tick();
    req_valid = 2'b00;
    n_checks++; if (stat_ops !== 16'd2) begin n_fail++; $display("FAIL stats_ops2: got %0d exp 2", stat_ops); end
    n_checks++; if (stat_sat !== 16'd4) begin n_fail++; $display("FAIL stats_sat2: got %0d exp 4", stat_sat); end
    n_checks++; if (rsp_data !== 16'h0002) begin n_fail++; $display("FAIL stats_data2: got %h exp 0002", rsp_data); end
    tick();
  endtask
`endif

  // -------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_reset_ptr();
`ifdef PADDSB_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paddsb_arb.md
Name: paddsb_arb

Overview:
- Shares one 16-bit PADDSB unit among NREQ requesters, e.g. the ALU issue port and the vector-accumulate engine.
- PADDSB: four independent 4-bit two's-complement lanes with saturating add.
- Round-robin arbitration; valid/ready on both sides; result held in a one-entry registered output slot.
- Sits between the execute-stage issue logic and the shared saturating-add datapath.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- IDW, 1, width of rsp_id; must equal clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  16*NREQ  operand A; requester i occupies bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept; combinational.
- rsp_valid  out  1  output slot holds a result.
- rsp_data  out  16  saturated lane-wise sum.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_ovfl  out  4  per-lane saturation flag; bit n = lane n, bits [4n+3:4n].
- rsp_ready  in  1  consumer accepts the result.

Behaviour:
- Lane arithmetic: s = a_n + b_n, 4-bit.
  - Overflow when a_n[3]==b_n[3] and s[3]!=a_n[3].
  - On overflow the lane result is 4'h7 if a_n[3]==0, else 4'h8; the lane ovfl bit is set.
  - No carry crosses lanes.
- Slot FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- slot_free = EMPTY | (rsp_valid & rsp_ready). Arbitration and draining overlap in one cycle.
- Grant: if slot_free, the winner is the first requester with req_valid=1, searching from ptr upward modulo NREQ. Only the winner's req_ready is 1; all req_ready bits are 0 when slot_free=0.
- Accept (req_valid[i] & req_ready[i]):
  - Next edge: rsp_data, rsp_ovfl and rsp_id load from requester i; state becomes FULL; ptr becomes (i+1) mod NREQ.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Drain with no accept: FULL -> EMPTY; rsp_data, rsp_id and rsp_ovfl keep their last values.
- Drain and accept in the same cycle: state stays FULL and the slot takes the new result; rsp_valid stays high with no bubble.
- FULL with rsp_ready=0: all outputs held stable, no grants, ptr unchanged.
- No valid requests: ptr unchanged.
- Requester protocol: once asserted, req_valid and operands are held until accepted. The block need not tolerate withdrawal, but must not grant a requester whose req_valid=0.
- Reset (async, any time, including with the slot FULL):
  - rsp_valid=0, rsp_data=16'h0000, rsp_id=0, rsp_ovfl=4'h0, ptr=0, state EMPTY.
  - Any held result is discarded.
  - req_ready is forced to 0 while rst=1.
  - The first grant after reset favours requester 0.

Optional Feature:
- Macro: PADDSB_ARB_STATS_EN.
- Defined: adds two outputs, each reset to 0 and wrapping at 16'hFFFF -> 0.
  - stat_ops (16 bits): increments by 1 per accept.
  - stat_sat (16 bits): increments by popcount of the new result's ovfl bits per accept.
- Not defined: both ports and both counters are absent; all other behaviour is identical.

Decomposition:
- Package paddsb_pkg:
  - NIB_W=4, NLANES=4, SAT_POS=4'h7, SAT_NEG=4'h8.
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
  - typedef logic [15:0] word_t.
- Sub-module paddsb_lane: combinational 4-bit saturating add.
  - Ports: a, b, sum, ovfl.
  - Instantiated 4x on the muxed winner operands.

Test Plan:
- Reset/basic: hold rst=1, then drive req0 a=16'h1234 b=16'h1111 -> req_ready=0 during reset. After release: req_ready[0]=1, then next cycle rsp_valid=1, rsp_data=16'h2345, rsp_id=0, rsp_ovfl=4'b0000.
- Saturation:
  - a=16'h7777 b=16'h1111 -> rsp_data=16'h7777, ovfl=4'b1111.
  - a=16'h8888 b=16'hFFFF -> rsp_data=16'h8888, ovfl=4'b1111.
  - a=16'h7F80 b=16'h1F80 -> rsp_data=16'h7E80, ovfl=4'b1010.
- Round-robin: req0 and req1 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1 on back-to-back cycles; rsp_valid stays high with no bubbles.
- Backpressure: slot FULL, rsp_ready=0, req1 valid -> req_ready=2'b00 and rsp_data/rsp_id stable for 5 cycles. Raise rsp_ready -> req1 accepted that cycle; next cycle rsp_id=1 with its result and rsp_valid still 1.
- Async reset mid-operation: pulse rst between clock edges while FULL -> rsp_valid falls before the next edge. Next grant with req0 and req1 both valid goes to requester 0.
- Stats (PADDSB_ARB_STATS_EN defined): issue 16'h7777+16'h1111, then 16'h0001+16'h0001 -> stat_ops=2, stat_sat=4.
